// File: rtl/ram_wipe_ctrl.sv
// RAM wipe controller and CPU/RAM bus arbiter.
// Zeroes every RAM word after reset or on request, then hands the bus back to the CPU.
module ram_wipe_ctrl #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter bit          AUTO_WIPE  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wipe_start,
    output logic                  busy,
    output logic                  done,
    input  logic                  cpu_cs,
    input  logic [3:0]            cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic [31:0]           cpu_write_data,
    output logic [31:0]           cpu_read_data,
    output logic                  cpu_ready,
    output logic                  ram_cs,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [31:0]           ram_write_data,
    input  logic [31:0]           ram_read_data,
    input  logic                  ram_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WIPE   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] wipe_addr;
    logic                  done_reg;

    // Sequencer: wipe_addr only advances on an accepted RAM write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= AUTO_WIPE ? WIPE : IDLE;
            wipe_addr <= '0;
            done_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wipe_start) begin
                        state     <= WIPE;
                        wipe_addr <= '0;
                        done_reg  <= 1'b0;
                    end
                end
                WIPE: begin
                    if (ram_ready) begin
                        if (wipe_addr == '1) begin
                            state <= FINISH;
                        end else begin
                            wipe_addr <= wipe_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                FINISH: begin
                    done_reg <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus mux: CPU pass-through in IDLE, controller owns the RAM otherwise.
    always_comb begin
        ram_cs         = cpu_cs;
        ram_we         = cpu_we;
        ram_address    = cpu_address;
        ram_write_data = cpu_write_data;
        cpu_read_data  = ram_read_data;
        cpu_ready      = ram_ready;
        busy           = 1'b0;
        case (state)
            WIPE: begin
                ram_cs         = 1'b1;
                ram_we         = 4'hf;
                ram_address    = wipe_addr;
                ram_write_data = 32'h0;
                cpu_read_data  = 32'h0;
                cpu_ready      = 1'b0;
                busy           = 1'b1;
            end
            FINISH: begin
                ram_cs        = 1'b0;
                ram_we        = 4'h0;
                cpu_read_data = 32'h0;
                cpu_ready     = 1'b0;
                busy          = 1'b1;
            end
            default: ;
        endcase
    end

    assign done = done_reg;

endmodule

// File: tb/tb_ram_wipe_ctrl.sv
// Directed bench for ram_wipe_ctrl with ADDR_WIDTH = 4 and a 16-word byte-lane RAM model.
module tb_ram_wipe_ctrl;

    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wipe_start;
    logic          busy, done;
    logic          cpu_cs;
    logic [3:0]    cpu_we;
    logic [AW-1:0] cpu_address;
    logic [31:0]   cpu_write_data;
    logic [31:0]   cpu_read_data;
    logic          cpu_ready;
    logic          ram_cs;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_address;
    logic [31:0]   ram_write_data;
    logic [31:0]   ram_read_data;
    logic          ram_ready;

    logic          ws0;
    logic          busy0, done0;
    logic [31:0]   cpu_read_data0;
    logic          cpu_ready0;
    logic          ram_cs0;
    logic [3:0]    ram_we0;
    logic [AW-1:0] ram_address0;
    logic [31:0]   ram_write_data0;
    logic [31:0]   rd0 = 32'hcafef00d;
    logic          rdy0 = 1'b1;

    logic          fill;
    logic          ready_mode;
    logic          rdy_tog;
    logic [31:0]   mem [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_wipe_ctrl #(.ADDR_WIDTH(AW), .AUTO_WIPE(1'b1)) u_dut (
        .clk(clk), .reset_n(reset_n), .wipe_start(wipe_start),
        .busy(busy), .done(done),
        .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_address(cpu_address),
        .cpu_write_data(cpu_write_data), .cpu_read_data(cpu_read_data),
        .cpu_ready(cpu_ready),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_address(ram_address),
        .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
        .ram_ready(ram_ready)
    );

    ram_wipe_ctrl #(.ADDR_WIDTH(AW), .AUTO_WIPE(1'b0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .wipe_start(ws0),
        .busy(busy0), .done(done0),
        .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_address(cpu_address),
        .cpu_write_data(cpu_write_data), .cpu_read_data(cpu_read_data0),
        .cpu_ready(cpu_ready0),
        .ram_cs(ram_cs0), .ram_we(ram_we0), .ram_address(ram_address0),
        .ram_write_data(ram_write_data0), .ram_read_data(rd0),
        .ram_ready(rdy0)
    );

    // RAM model: combinational read, byte-lane write on an accepted access.
    always @(posedge clk) begin
        rdy_tog <= ready_mode ? ~rdy_tog : 1'b1;
        if (fill) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hdeadbeef;
        end else if (ram_cs && ram_ready) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_address][8*b +: 8] <= ram_write_data[8*b +: 8];
        end
    end

    assign ram_ready     = ready_mode ? rdy_tog : 1'b1;
    assign ram_read_data = mem[ram_address];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered in the first busy cycle; returns the number of busy cycles.
    task automatic run_wipe(input int pulse_at, input int reset_at, output int cycles);
        int exp_addr;
        bit hit_p;
        bit hit_r;
        exp_addr = 0;
        hit_p = 1'b0;
        hit_r = 1'b0;
        cycles = 0;
        while (busy && cycles < 200) begin
            cycles++;
            chk("busy_cpu_ready", 32'(cpu_ready), 32'h0);
            if (ram_cs) begin
                chk("wipe_addr", 32'(ram_address), 32'(exp_addr));
                chk("wipe_we", 32'(ram_we), 32'hf);
                chk("wipe_data", ram_write_data, 32'h0);
                if (ram_ready) exp_addr++;
            end else begin
                chk("finish_done", 32'(done), 32'h0);
            end
            if (!hit_p && pulse_at >= 0 && ram_cs && 32'(ram_address) == 32'(pulse_at)) begin
                wipe_start = 1'b1;
                hit_p = 1'b1;
            end
            if (!hit_r && reset_at >= 0 && ram_cs && 32'(ram_address) == 32'(reset_at)) begin
                reset_n = 1'b0;
                hit_r = 1'b1;
            end
            @(negedge clk);
            wipe_start = 1'b0;
            if (!reset_n) begin
                reset_n = 1'b1;
                exp_addr = 0;
                cycles = 0;
                #1;
                chk("reset_done", 32'(done), 32'h0);
                chk("reset_busy", 32'(busy), 32'h1);
            end else begin
                #1;
            end
        end
    endtask

    task automatic start_wipe();
        @(negedge clk);
        wipe_start = 1'b1;
        @(negedge clk);
        wipe_start = 1'b0;
        #1;
        chk("req_busy", 32'(busy), 32'h1);
        chk("req_done", 32'(done), 32'h0);
        chk("req_addr", 32'(ram_address), 32'h0);
    endtask

    task automatic check_zero();
        for (int i = 0; i < 16; i++) chk($sformatf("mem_zero[%0d]", i), mem[i], 32'h0);
    endtask

    typedef struct {
        logic [3:0]    we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   exp_rdata;
    } vec_t;

    vec_t vecs [7];
    int   cyc;

    initial begin
        vecs[0] = '{4'h3, 4'd3,  32'h12345678, 32'h00000000};
        vecs[1] = '{4'h0, 4'd3,  32'h00000000, 32'h00005678};
        vecs[2] = '{4'hc, 4'd3,  32'haabbccdd, 32'h00005678};
        vecs[3] = '{4'h0, 4'd3,  32'h00000000, 32'haabb5678};
        vecs[4] = '{4'hf, 4'd15, 32'h0badf00d, 32'h00000000};
        vecs[5] = '{4'h0, 4'd15, 32'h00000000, 32'h0badf00d};
        vecs[6] = '{4'h0, 4'd0,  32'h00000000, 32'h00000000};

        reset_n = 1'b0;
        wipe_start = 1'b0;
        ws0 = 1'b0;
        fill = 1'b1;
        ready_mode = 1'b0;
        cpu_cs = 1'b1;
        cpu_we = 4'h0;
        cpu_address = 4'd2;
        cpu_write_data = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'h1);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_busy0", 32'(busy0), 32'h0);
        chk("rst_done0", 32'(done0), 32'h0);
        chk("rst_pass_cs0", 32'(ram_cs0), 32'h1);
        chk("rst_pass_rd0", cpu_read_data0, 32'hcafef00d);
        chk("rst_pass_rdy0", 32'(cpu_ready0), 32'h1);

        // Auto-wipe with a CPU read held across it.
        @(negedge clk);
        fill = 1'b0;
        reset_n = 1'b1;
        #1;
        run_wipe(-1, -1, cyc);
        chk("auto_cycles", 32'(cyc), 32'd17);
        chk("auto_done", 32'(done), 32'h1);
        chk("held_ready", 32'(cpu_ready), 32'h1);
        chk("held_rdata", cpu_read_data, 32'h0);
        check_zero();

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            cpu_cs = 1'b1;
            cpu_we = vecs[i].we;
            cpu_address = vecs[i].addr;
            cpu_write_data = vecs[i].wdata;
            #1;
            chk($sformatf("pass_cs[%0d]", i), 32'(ram_cs), 32'h1);
            chk($sformatf("pass_we[%0d]", i), 32'(ram_we), 32'(vecs[i].we));
            chk($sformatf("pass_addr[%0d]", i), 32'(ram_address), 32'(vecs[i].addr));
            chk($sformatf("pass_wdata[%0d]", i), ram_write_data, vecs[i].wdata);
            chk($sformatf("pass_ready[%0d]", i), 32'(cpu_ready), 32'h1);
            chk($sformatf("pass_rdata[%0d]", i), cpu_read_data, vecs[i].exp_rdata);
            chk($sformatf("pass_busy[%0d]", i), 32'(busy), 32'h0);
        end

        // Wipe with ram_ready low every other cycle.
        @(negedge clk);
        cpu_cs = 1'b0;
        cpu_we = 4'h0;
        fill = 1'b1;
        @(negedge clk);
        fill = 1'b0;
        ready_mode = 1'b1;
        wipe_start = 1'b1;
        @(negedge clk);
        wipe_start = 1'b0;
        #1;
        chk("slow_req_busy", 32'(busy), 32'h1);
        chk("slow_req_done", 32'(done), 32'h0);
        run_wipe(-1, -1, cyc);
        ready_mode = 1'b0;
        chk("slow_cycles", 32'(cyc), 32'd33);
        chk("slow_done", 32'(done), 32'h1);
        check_zero();

        // wipe_start mid-wipe is ignored.
        start_wipe();
        run_wipe(5, -1, cyc);
        chk("ignore_cycles", 32'(cyc), 32'd17);
        chk("ignore_done", 32'(done), 32'h1);

        // Reset mid-wipe restarts from word 0.
        start_wipe();
        run_wipe(-1, 9, cyc);
        chk("abort_cycles", 32'(cyc), 32'd17);
        chk("abort_done", 32'(done), 32'h1);

        // AUTO_WIPE = 0 instance: wipe only on request.
        @(negedge clk);
        chk("manual_idle_busy0", 32'(busy0), 32'h0);
        ws0 = 1'b1;
        @(negedge clk);
        ws0 = 1'b0;
        #1;
        chk("manual_busy0", 32'(busy0), 32'h1);
        chk("manual_cs0", 32'(ram_cs0), 32'h1);
        chk("manual_addr0", 32'(ram_address0), 32'h0);
        chk("manual_we0", 32'(ram_we0), 32'hf);
        chk("manual_rdy0", 32'(cpu_ready0), 32'h0);
        cyc = 0;
        while (busy0 && cyc < 100) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        chk("manual_cycles0", 32'(cyc), 32'd17);
        chk("manual_done0", 32'(done0), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
